// File: rtl/pixel_write_fifo.sv
// pixel_write_fifo
// Buffers surviving pixel pairs coming out of the Z-compare stage and turns
// each one into Avalon-MM 64-bit SDRAM writes: a color write, followed by a
// Z write when z_active was set when the entry reached LOAD. Per-pixel byte
// enables come from pixel_active (bit 0 = left pixel = low 32 bits).
//
// Optional feature macro: PIXEL_WRITE_COUNT_EN
//   When defined, adds output pixels_written, which counts the pixels covered
//   by accepted color writes (wraps modulo 2^32).
//
// Ports:
//   clock, reset_n           clock (rising edge) and async active-low reset
//   z_active                 issue a Z write after the color write
//   enqueue                  push one entry this cycle
//   color_address, color     color word address / two 32-bit color pixels
//   z_address, z             Z word address / two 32-bit Z values
//   pixel_active             per-pixel enable, bit 0 = left pixel
//   size, full, overflow     occupancy, full flag, sticky dropped-push flag
//   busy                     FIFO non-empty or a write sequence in progress
//   write_*                  Avalon-MM write master (registered outputs)
//   pixels_written           (PIXEL_WRITE_COUNT_EN only) pixel write counter
module pixel_write_fifo #(
   parameter int FIFO_DEPTH      = 32,
   parameter int FIFO_DEPTH_LOG2 = 5
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     z_active,
   input  logic                     enqueue,
   input  logic [28:0]              color_address,
   input  logic [63:0]              color,
   input  logic [28:0]              z_address,
   input  logic [63:0]              z,
   input  logic [1:0]               pixel_active,
   output logic [FIFO_DEPTH_LOG2:0] size,
   output logic                     full,
   output logic                     overflow,
   output logic                     busy,
   output logic [28:0]              write_address,
   output logic [63:0]              write_writedata,
   output logic [7:0]               write_byteenable,
   output logic                     write_write,
   input  logic                     write_waitrequest
`ifdef PIXEL_WRITE_COUNT_EN
   ,
   output logic [31:0]              pixels_written
`endif
);

   localparam int ENTRY_W = 188;
   localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_C = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_COLOR = 2'd2,
      S_Z     = 2'd3
   } state_t;

   // Storage and pointers
   logic [ENTRY_W-1:0]       mem_q [FIFO_DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_DEPTH_LOG2:0] count_q, count_d;
   logic                     overflow_q;
   logic                     push, pop, full_w;

   // Write sequencer
   state_t                   state_q, state_d;
   logic [ENTRY_W-1:0]       head_q;
   logic                     zact_q, zact_d;
   logic                     ww_q, ww_d;
   logic [28:0]              wa_q, wa_d;
   logic [63:0]              wd_q, wd_d;
   logic [7:0]               be_q, be_d;

   // Fields of the entry currently owned by the sequencer
   logic [28:0]              e_ca, e_za;
   logic [63:0]              e_color, e_z;
   logic [1:0]               e_pa;

   assign e_ca    = head_q[28:0];
   assign e_color = head_q[92:29];
   assign e_za    = head_q[121:93];
   assign e_z     = head_q[185:122];
   assign e_pa    = head_q[187:186];

   assign full_w = (count_q == DEPTH_C);
   assign pop    = (state_q == S_IDLE) && (count_q != '0);
   // A push into a full FIFO is still accepted when the head leaves the same cycle.
   assign push   = enqueue && (!full_w || pop);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // ---- FIFO control ----
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (enqueue && !push) overflow_q <= 1'b1;
      end
   end

   // Entry storage carries no reset; only the pointers define validity.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= {pixel_active, z, z_address, color, color_address};
   end

   // The head entry is captured as it is popped and stays put until the next pop,
   // which cannot happen before the sequencer is back in IDLE.
   always_ff @(posedge clock) begin
      if (pop) head_q <= mem_q[rd_ptr_q];
   end

   // ---- Sequencer state register ----
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         zact_q  <= 1'b0;
         ww_q    <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         zact_q  <= zact_d;
         ww_q    <= ww_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         be_q    <= be_d;
      end
   end

   // ---- Sequencer next state / registered output values ----
   always_comb begin
      state_d = state_q;
      zact_d  = zact_q;
      ww_d    = ww_q;
      wa_d    = wa_q;
      wd_d    = wd_q;
      be_d    = be_q;
      case (state_q)
         S_IDLE: begin
            ww_d = 1'b0;
            if (pop) state_d = S_LOAD;
         end
         S_LOAD: begin
            // z_active is sampled here, so later changes only affect later entries.
            zact_d = z_active;
            if (e_pa == 2'b00) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_COLOR;
               ww_d    = 1'b1;
               wa_d    = e_ca;
               wd_d    = e_color;
               be_d    = {{4{e_pa[1]}}, {4{e_pa[0]}}};
            end
         end
         S_COLOR: begin
            if (!write_waitrequest) begin
               if (zact_q) begin
                  state_d = S_Z;
                  wa_d    = e_za;
                  wd_d    = e_z;
               end else begin
                  state_d = S_IDLE;
                  ww_d    = 1'b0;
               end
            end
         end
         S_Z: begin
            if (!write_waitrequest) begin
               state_d = S_IDLE;
               ww_d    = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            ww_d    = 1'b0;
         end
      endcase
   end

`ifdef PIXEL_WRITE_COUNT_EN
   logic [31:0] pix_q;

   // ---- Pixel counter: bumps once per accepted color write ----
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pix_q <= '0;
      end else if ((state_q == S_COLOR) && !write_waitrequest) begin
         pix_q <= pix_q + {31'd0, e_pa[1]} + {31'd0, e_pa[0]};
      end
   end

   assign pixels_written = pix_q;
`endif

   assign size             = count_q;
   assign full             = full_w;
   assign overflow         = overflow_q;
   assign busy             = (count_q != '0) || (state_q != S_IDLE);
   assign write_write      = ww_q;
   assign write_address    = wa_q;
   assign write_writedata  = wd_q;
   assign write_byteenable = be_q;

endmodule

// File: tb/tb_pixel_write_fifo.sv
module tb_pixel_write_fifo;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        z_active;
   logic        enqueue;
   logic [28:0] color_address;
   logic [63:0] color;
   logic [28:0] z_address;
   logic [63:0] z;
   logic [1:0]  pixel_active;
   logic [5:0]  size;
   logic        full;
   logic        overflow;
   logic        busy;
   logic [28:0] write_address;
   logic [63:0] write_writedata;
   logic [7:0]  write_byteenable;
   logic        write_write;
   logic        write_waitrequest;
`ifdef PIXEL_WRITE_COUNT_EN
   logic [31:0] pixels_written;
`endif

   pixel_write_fifo #(.FIFO_DEPTH(32), .FIFO_DEPTH_LOG2(5)) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .z_active          (z_active),
      .enqueue           (enqueue),
      .color_address     (color_address),
      .color             (color),
      .z_address         (z_address),
      .z                 (z),
      .pixel_active      (pixel_active),
      .size              (size),
      .full              (full),
      .overflow          (overflow),
      .busy              (busy),
      .write_address     (write_address),
      .write_writedata   (write_writedata),
      .write_byteenable  (write_byteenable),
      .write_write       (write_write),
      .write_waitrequest (write_waitrequest)
`ifdef PIXEL_WRITE_COUNT_EN
      ,
      .pixels_written    (pixels_written)
`endif
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [28:0] a;
      logic [63:0] d;
      logic [7:0]  be;
   } wr_t;

   wr_t         exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   longint      exp_pix  = 0;
   bit          rand_ws  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference model: an accepted entry produces a color write and optionally a
   // Z write, both with byte enables expanded from pixel_active; pa==0 produces nothing.
   task automatic model_push(input logic [28:0] ca, input logic [63:0] col,
                             input logic [28:0] za, input logic [63:0] zv,
                             input logic [1:0] pa, input logic zact);
      wr_t w;
      logic [7:0] be;
      if (pa != 2'b00) begin
         be = 8'h00;
         if (pa[0]) be = be | 8'h0F;
         if (pa[1]) be = be | 8'hF0;
         w.a = ca; w.d = col; w.be = be;
         exp_q.push_back(w);
         if (zact) begin
            w.a = za; w.d = zv;
            exp_q.push_back(w);
         end
         exp_pix += int'(pa[0]) + int'(pa[1]);
      end
   endtask

   // Monitor: every write the slave accepts must match the head of the scoreboard.
   always @(negedge clock) begin
      wr_t e;
      if (reset_n && write_write && !write_waitrequest) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     write_address, write_writedata);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(write_address), 64'(e.a));
            check("wr_data", write_writedata, e.d);
            check("wr_be", 64'(write_byteenable), 64'(e.be));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      if (rand_ws) write_waitrequest = 1'($urandom_range(0, 1));
   endtask

   // Drives one entry for a single clock edge; returns 1 ns after that edge.
   task automatic enq(input logic [28:0] ca, input logic [63:0] col,
                      input logic [28:0] za, input logic [63:0] zv,
                      input logic [1:0] pa, input bit accepted);
      color_address = ca; color = col; z_address = za; z = zv; pixel_active = pa;
      enqueue = 1'b1;
      if (accepted) model_push(ca, col, za, zv, pa, z_active);
      tick();
      enqueue = 1'b0;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (busy && t < 3000) begin
         tick();
         t++;
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, t);
      end
      write_waitrequest = 1'b0;
      tick();
      check({name, "_busy"}, 64'(busy), 64'd0);
      check({name, "_size"}, 64'(size), 64'd0);
      check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
`ifdef PIXEL_WRITE_COUNT_EN
      check({name, "_pixcnt"}, 64'(pixels_written), 64'(exp_pix[31:0]));
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      wr_t dummy;
      reset_n = 1'b0; z_active = 1'b0; enqueue = 1'b0;
      color_address = '0; color = '0; z_address = '0; z = '0; pixel_active = '0;
      write_waitrequest = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      tick();

      // ---- Reset state ----
      check("rst_size", 64'(size), 64'd0);
      check("rst_full", 64'(full), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ww", 64'(write_write), 64'd0);
      check("rst_addr", 64'(write_address), 64'd0);
      check("rst_data", write_writedata, 64'd0);
      check("rst_be", 64'(write_byteenable), 64'd0);
`ifdef PIXEL_WRITE_COUNT_EN
      check("rst_pixcnt", 64'(pixels_written), 64'd0);
`endif

      // ---- Latency and color+Z sequence ----
      z_active = 1'b1;
      enq(29'h100, 64'h11112222_33334444, 29'h200, 64'h00000005_00000006, 2'b11, 1'b1);
      @(negedge clock); check("lat_ww_n", 64'(write_write), 64'd0);
      check("lat_size_n", 64'(size), 64'd1);
      @(negedge clock); check("lat_ww_n1", 64'(write_write), 64'd0);
      check("lat_size_n1", 64'(size), 64'd0);
      @(negedge clock); check("lat_ww_n2", 64'(write_write), 64'd1);
      #1;
      drain("colz");

      // ---- Byte-enable patterns, no Z ----
      z_active = 1'b0;
      enq(29'h300, 64'hAAAA_BBBB_CCCC_DDDD, 29'h400, 64'h1, 2'b01, 1'b1);
      drain("pa01");
      enq(29'h301, 64'h0123_4567_89AB_CDEF, 29'h401, 64'h2, 2'b10, 1'b1);
      drain("pa10");
      enq(29'h302, 64'hDEAD_BEEF_0000_0001, 29'h402, 64'h3, 2'b00, 1'b1);
      drain("pa00");

      // ---- Stall during COLOR ----
      z_active = 1'b1;
      write_waitrequest = 1'b1;
      enq(29'h155, 64'h5555_6666_7777_8888, 29'h255, 64'h9999_AAAA_BBBB_CCCC, 2'b11, 1'b1);
      @(posedge clock);
      @(posedge clock);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("stall_ww", 64'(write_write), 64'd1);
         check("stall_addr", 64'(write_address), 64'h155);
         check("stall_data", write_writedata, 64'h5555_6666_7777_8888);
         check("stall_be", 64'(write_byteenable), 64'hFF);
      end
      @(posedge clock);
      #1 write_waitrequest = 1'b0;
      drain("stall");

      // ---- Randomized bursts (kept under FIFO depth) ----
      for (int b = 0; b < 8; b++) begin
         rand_ws  = 1'b1;
         z_active = 1'($urandom_range(0, 1));
         for (int k = 0; k < int'($urandom_range(5, 24)); k++) begin
            repeat ($urandom_range(0, 2)) tick();
            enq(29'($urandom), {$urandom(), $urandom()}, 29'($urandom),
                {$urandom(), $urandom()}, 2'($urandom_range(0, 3)), 1'b1);
         end
         drain("rand");
         rand_ws = 1'b0;
      end

      // ---- Fill and overflow ----
      // The first entry leaves the FIFO into the (stalled) write stage, so
      // entries 0..32 fit and entry 33 is the first one dropped.
      z_active = 1'b0;
      write_waitrequest = 1'b1;
      for (int i = 0; i < 34; i++) begin
         enq(29'(32'h1000 + i), {32'(i), 32'hC0C0_0000 + 32'(i)}, 29'h0, 64'h0,
             2'b11, (i < 33));
         if (i == 32) begin
            check("fill_size", 64'(size), 64'd32);
            check("fill_full", 64'(full), 64'd1);
            check("fill_no_ovf", 64'(overflow), 64'd0);
         end
      end
      check("ovf_size", 64'(size), 64'd32);
      check("ovf_flag", 64'(overflow), 64'd1);
      write_waitrequest = 1'b0;
      drain("ovf");
      check("ovf_sticky", 64'(overflow), 64'd1);
      check("ovf_full_clr", 64'(full), 64'd0);

      // ---- Reset while stalled in Z ----
      z_active = 1'b1;
      write_waitrequest = 1'b0;
      enq(29'h0AA, 64'h1, 29'h0BB, 64'h2, 2'b11, 1'b1);
      enq(29'h0AC, 64'h3, 29'h0BD, 64'h4, 2'b01, 1'b1);
      enq(29'h0AE, 64'h5, 29'h0BF, 64'h6, 2'b10, 1'b1);
      @(posedge clock);
      #1 write_waitrequest = 1'b1;
      @(negedge clock);
      check("zrst_in_z_ww", 64'(write_write), 64'd1);
      check("zrst_in_z_addr", 64'(write_address), 64'h0BB);
      #2 reset_n = 1'b0;
      #1;
      check("zrst_ww", 64'(write_write), 64'd0);
      check("zrst_size", 64'(size), 64'd0);
      check("zrst_overflow", 64'(overflow), 64'd0);
      check("zrst_busy", 64'(busy), 64'd0);
      while (exp_q.size() != 0) dummy = exp_q.pop_front();
      exp_pix = 0;
      @(posedge clock);
      #1 reset_n = 1'b1;
      write_waitrequest = 1'b0;
      enq(29'h1234, 64'hFEED_FACE_CAFE_BABE, 29'h5678, 64'h0BAD_F00D_1357_2468, 2'b11, 1'b1);
      drain("post_rst");

`ifdef PIXEL_WRITE_COUNT_EN
      // ---- Pixel counter ----
      reset_n = 1'b0;
      #1;
      while (exp_q.size() != 0) dummy = exp_q.pop_front();
      exp_pix = 0;
      @(posedge clock);
      #1 reset_n = 1'b1;
      z_active = 1'b0;
      enq(29'h10, 64'h1, 29'h20, 64'h0, 2'b11, 1'b1);
      enq(29'h11, 64'h2, 29'h21, 64'h0, 2'b01, 1'b1);
      enq(29'h12, 64'h3, 29'h22, 64'h0, 2'b00, 1'b1);
      drain("pixcnt");
      check("pixcnt_three", 64'(pixels_written), 64'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
